// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle MIPS core: multiply/divide FSM states,
// operation encoding and the R-type funct codes the control unit decodes.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } md_op_t;

    localparam logic [5:0] FUNCT_MFHI = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO = 6'b010010;
    localparam logic [5:0] FUNCT_MULT = 6'b011000;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit owning the architectural HI/LO
// registers. Works on operand magnitudes (shift-add multiply, restoring
// divide, one bit per cycle) and applies the result signs in a final FIX step.
module mult_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int                CNT_W     = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(WIDTH - 1);

    md_state_t          state, next_state;
    md_op_t             op;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               sign_a, sign_b;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, remaining dividend / quotient bits}.
    logic [2*WIDTH-1:0] prod;

    logic               accept_mult, accept_div, div_by_zero;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mult_sum, div_trial, div_diff;
    logic [2*WIDTH-1:0] calc_next, prod_signed;
    logic [WIDTH-1:0]   quo_signed, rem_signed;

    // State register.
    // NOTE: every clocked block uses non-blocking assignments so all
    // registers update together from values sampled before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Start decode and next-state logic; mult wins when both starts are high.
    // NOTE: every combinational output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        accept_mult = start_mult;
        accept_div  = start_div && !start_mult && (B != '0);
        div_by_zero = start_div && !start_mult && (B == '0);
        next_state  = state;
        case (state)
            IDLE:    if (accept_mult || accept_div) next_state = CALC;
            CALC:    if (cnt == LAST_ITER)          next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand magnitudes, one iteration step, and the sign-corrected results.
    always_comb begin
        a_abs     = A[WIDTH-1] ? ('0 - A) : A;
        b_abs     = B[WIDTH-1] ? ('0 - B) : B;

        mult_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, a_mag} : '0);
        div_trial = prod[2*WIDTH-1:WIDTH-1];
        div_diff  = div_trial - {1'b0, b_mag};

        if (op == OP_MULT)
            calc_next = {mult_sum, prod[WIDTH-1:1]};
        else if (div_diff[WIDTH])
            calc_next = {div_trial[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
        else
            calc_next = {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};

        prod_signed = (sign_a ^ sign_b) ? ('0 - prod) : prod;
        quo_signed  = (sign_a ^ sign_b) ? ('0 - prod[WIDTH-1:0]) : prod[WIDTH-1:0];
        rem_signed  = sign_a ? ('0 - prod[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
    end

    // Datapath and registered outputs: latch operands, iterate, write HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op       <= OP_MULT;
            cnt      <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            prod     <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_mult || accept_div) begin
                        a_mag  <= a_abs;
                        b_mag  <= b_abs;
                        sign_a <= A[WIDTH-1];
                        sign_b <= B[WIDTH-1];
                        op     <= accept_mult ? OP_MULT : OP_DIV;
                        prod   <= accept_mult ? {{WIDTH{1'b0}}, b_abs} : {{WIDTH{1'b0}}, a_abs};
                        cnt    <= '0;
                        busy   <= 1'b1;
                    end else if (div_by_zero) begin
                        done     <= 1'b1;
                        div_zero <= 1'b1;
                    end
                end
                CALC: begin
                    prod <= calc_next;
                    cnt  <= cnt + 1'b1;
                end
                FIX: begin
                    if (op == OP_MULT) begin
                        hi <= prod_signed[2*WIDTH-1:WIDTH];
                        lo <= prod_signed[WIDTH-1:0];
                    end else begin
                        hi <= rem_signed;
                        lo <= quo_signed;
                    end
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: reset, signed multiply and
// divide, divide-by-zero, start protocol corner cases, reset mid-operation.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    int vectors = 0;
    int miscompares = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .A          (A),
        .B          (B),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    // Wait (bounded) for done, counting cycles and cycles with busy high.
    task automatic wait_done(output int cyc, output int bcyc);
        cyc  = 0;
        bcyc = busy ? 1 : 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (busy) bcyc++;
        end
    endtask

    // Pulse a start for one cycle (from a negedge) and wait for done.
    task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         output int cyc, output int bcyc);
        @(negedge clk);
        start_mult = m; start_div = d; A = a; B = b;
        @(negedge clk);
        start_mult = 1'b0; start_div = 1'b0;
        wait_done(cyc, bcyc);
    endtask

    task automatic test_reset;
        #1;
        vectors++;
        if ({hi, lo, busy, done, div_zero} !== 67'd0) begin
            miscompares++;
            $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dz=%b, want all 0", hi, lo, busy, done, div_zero);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult;
        logic [31:0] av [3] = '{32'hFFFFFFFE, 32'h7FFFFFFF, 32'h80000000};
        logic [31:0] bv [3] = '{32'h00000003, 32'h00000002, 32'h80000000};
        logic [63:0] ev [3] = '{64'hFFFFFFFF_FFFFFFFA, 64'h00000000_FFFFFFFE, 64'h40000000_00000000};
        int cyc, bcyc;
        for (int i = 0; i < 3; i++) begin
            do_op(1'b1, 1'b0, av[i], bv[i], cyc, bcyc);
            vectors++;
            if ({hi, lo} !== ev[i] || cyc != 33 || bcyc != 33) begin
                miscompares++;
                $display("FAIL mult_%0d: hi:lo=%h cyc=%0d busy_cyc=%0d, want %h cyc=33 busy_cyc=33", i, {hi, lo}, cyc, bcyc, ev[i]);
            end
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("FAIL mult_done_width_%0d: done=%b one cycle after pulse, want 0", i, done);
            end
        end
    endtask

    task automatic test_div_signs;
        logic [31:0] av [4] = '{32'd7, 32'hFFFFFFF9, 32'h80000000, 32'd100};
        logic [31:0] bv [4] = '{32'hFFFFFFFE, 32'd2, 32'hFFFFFFFF, 32'd7};
        logic [31:0] eq [4] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'd14};
        logic [31:0] er [4] = '{32'd1, 32'hFFFFFFFF, 32'd0, 32'd2};
        int cyc, bcyc;
        for (int i = 0; i < 4; i++) begin
            do_op(1'b0, 1'b1, av[i], bv[i], cyc, bcyc);
            vectors++;
            if (lo !== eq[i] || hi !== er[i] || div_zero !== 1'b0 || cyc != 33) begin
                miscompares++;
                $display("FAIL div_%0d: lo=%h hi=%h dz=%b cyc=%0d, want lo=%h hi=%h dz=0 cyc=33", i, lo, hi, div_zero, cyc, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_div_zero;
        int cyc, bcyc;
        do_op(1'b1, 1'b0, 32'd6, 32'd7, cyc, bcyc);   // HI:LO = 0:42
        @(negedge clk);
        start_div = 1'b1; A = 32'd5; B = 32'd0;
        @(negedge clk);
        start_div = 1'b0;
        vectors++;
        if (done !== 1'b1 || div_zero !== 1'b1 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd42) begin
            miscompares++;
            $display("FAIL div_zero_pulse: done=%b dz=%b busy=%b hi=%h lo=%h, want 1 1 0 0 2a", done, div_zero, busy, hi, lo);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || div_zero !== 1'b0 || busy !== 1'b0 || lo !== 32'd42) begin
            miscompares++;
            $display("FAIL div_zero_after: done=%b dz=%b busy=%b lo=%h, want 0 0 0 2a", done, div_zero, busy, lo);
        end
    endtask

    task automatic test_busy_ignore;
        int cyc, bcyc;
        @(negedge clk);
        start_mult = 1'b1; A = 32'd3; B = 32'd5;
        @(negedge clk);
        start_mult = 1'b0;
        repeat (4) @(negedge clk);
        start_div = 1'b1; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start_div = 1'b0;
        wait_done(cyc, bcyc);
        vectors++;
        if (hi !== 32'd0 || lo !== 32'd15 || cyc != 28) begin
            miscompares++;
            $display("FAIL busy_ignore: hi=%h lo=%h cyc=%0d, want 0 f cyc=28", hi, lo, cyc);
        end
    endtask

    task automatic test_both_starts;
        int cyc, bcyc;
        do_op(1'b1, 1'b1, 32'd9, 32'hFFFFFFFD, cyc, bcyc);
        vectors++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFE5) begin
            miscompares++;
            $display("FAIL both_starts: hi=%h lo=%h, want ffffffff ffffffe5", hi, lo);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, bcyc;
        do_op(1'b1, 1'b0, 32'd11, 32'd13, cyc, bcyc);
        // done is high now: issue the next start in this very cycle.
        start_div = 1'b1; A = 32'hFFFFFF9C; B = 32'd9;   // -100 / 9
        @(negedge clk);
        start_div = 1'b0;
        vectors++;
        if (busy !== 1'b1 || lo !== 32'd143) begin
            miscompares++;
            $display("FAIL b2b_accept: busy=%b lo=%h, want busy=1 lo=8f", busy, lo);
        end
        wait_done(cyc, bcyc);
        vectors++;
        if (lo !== 32'hFFFFFFF5 || hi !== 32'hFFFFFFFF || cyc != 33 || bcyc != 33) begin
            miscompares++;
            $display("FAIL b2b_result: lo=%h hi=%h cyc=%0d busy_cyc=%0d, want fffffff5 ffffffff 33 33", lo, hi, cyc, bcyc);
        end
    endtask

    task automatic test_reset_mid_op;
        int cyc, bcyc;
        @(negedge clk);
        start_mult = 1'b1; A = 32'd1234; B = 32'd5678;
        @(negedge clk);
        start_mult = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({hi, lo, busy, done, div_zero} !== 67'd0) begin
            miscompares++;
            $display("FAIL reset_mid_op: hi=%h lo=%h busy=%b done=%b dz=%b, want all 0", hi, lo, busy, done, div_zero);
        end
        @(negedge clk);
        reset = 1'b1;
        do_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, bcyc);
        vectors++;
        if (hi !== 32'd0 || lo !== 32'd1 || cyc != 33) begin
            miscompares++;
            $display("FAIL post_reset_mult: hi=%h lo=%h cyc=%0d, want 0 1 33", hi, lo, cyc);
        end
    endtask

    task automatic test_random;
        int cyc, bcyc;
        logic [31:0] a, b, eq, er;
        longint sa, sb, q, r;
        logic [63:0] ep;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            if (b == 32'd0) b = 32'd1;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            ep = 64'(sa * sb);
            do_op(1'b1, 1'b0, a, b, cyc, bcyc);
            vectors++;
            if ({hi, lo} !== ep || bcyc != 33) begin
                miscompares++;
                $display("FAIL rand_mult_%0d: %h*%h gave %h busy_cyc=%0d, want %h 33", i, a, b, {hi, lo}, bcyc, ep);
            end
            q = sa / sb;
            r = sa % sb;
            eq = q[31:0];
            er = r[31:0];
            do_op(1'b0, 1'b1, a, b, cyc, bcyc);
            vectors++;
            if (lo !== eq || hi !== er || bcyc != 33) begin
                miscompares++;
                $display("FAIL rand_div_%0d: %h/%h gave lo=%h hi=%h busy_cyc=%0d, want %h %h 33", i, a, b, lo, hi, bcyc, eq, er);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div_signs();
        test_div_zero();
        test_busy_ignore();
        test_both_starts();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
